// File: rtl/mem_access_ctl.sv
// mem_access_ctl -- data-memory stage sequencer for the MIPS datapath.
// Accepts one decoded instruction at a time, runs a req/ack transaction
// against data memory for loads/stores, and emits a single writeback beat.
// Optional build macro: MEM_ALIGN_CHECK_EN (reject word-misaligned accesses).
module mem_access_ctl #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        memToReg,
  input  logic        regWrite,
  input  logic [4:0]  writeReg,
  input  logic [31:0] aluResult,
  input  logic [31:0] storeData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_valid,
  output logic        wb_regWrite,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_t;

  // A limit of zero disables the timeout entirely.
  localparam logic [31:0] ACK_LIMIT = 32'(ACK_TIMEOUT);

`ifdef MEM_ALIGN_CHECK_EN
  // Word accesses must have the two low address bits clear.
  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction
`endif

  state_t      stateQ, stateD;
  logic        latRegWrite, latRegWriteD;
  logic        latMemToReg, latMemToRegD;
  logic        latIsRead, latIsReadD;
  logic [4:0]  latReg, latRegD;
  logic [31:0] latAlu, latAluD;
  logic [31:0] ackCnt, ackCntD;

  logic        memReqD, memWeD, wbValidD, wbRegWriteD, errD;
  logic [31:0] memAddrD, memWdataD, wbDataD;
  logic [4:0]  wbRegD;

  logic        acceptS, isMemS, alignErrS, ackLimitHitS;

  assign in_ready     = ((stateQ == IDLE) || (stateQ == WB)) && !reset;
  assign stall        = !in_ready;
  assign acceptS      = in_valid && in_ready;
  assign isMemS       = memRead || memWrite;
  assign ackLimitHitS = (ACK_LIMIT != 32'd0) && (ackCnt == (ACK_LIMIT - 32'd1));

`ifdef MEM_ALIGN_CHECK_EN
  assign alignErrS = misaligned(aluResult);
`else
  assign alignErrS = 1'b0;
`endif

  // Next-state and next-output logic; every output register defaults to 0.
  always_comb begin
    stateD       = stateQ;
    memReqD      = 1'b0;
    memWeD       = 1'b0;
    memAddrD     = 32'd0;
    memWdataD    = 32'd0;
    wbValidD     = 1'b0;
    wbRegWriteD  = 1'b0;
    wbRegD       = 5'd0;
    wbDataD      = 32'd0;
    errD         = 1'b0;
    latRegWriteD = latRegWrite;
    latMemToRegD = latMemToReg;
    latIsReadD   = latIsRead;
    latRegD      = latReg;
    latAluD      = latAlu;
    ackCntD      = ackCnt;
    case (stateQ)
      IDLE, WB: begin
        if (acceptS) begin
          if (isMemS && alignErrS) begin
            // Misaligned access: no memory cycle, flagged writeback only.
            stateD      = WB;
            wbValidD    = 1'b1;
            wbRegWriteD = 1'b0;
            wbRegD      = writeReg;
            wbDataD     = memToReg ? 32'd0 : aluResult;
            errD        = 1'b1;
          end else if (isMemS) begin
            // Store wins over load when both are set.
            stateD       = REQ;
            memReqD      = 1'b1;
            memWeD       = memWrite;
            memAddrD     = aluResult;
            memWdataD    = storeData;
            latRegWriteD = regWrite;
            latMemToRegD = memToReg;
            latIsReadD   = memRead && !memWrite;
            latRegD      = writeReg;
            latAluD      = aluResult;
            ackCntD      = 32'd0;
          end else begin
            stateD      = WB;
            wbValidD    = 1'b1;
            wbRegWriteD = regWrite;
            wbRegD      = writeReg;
            wbDataD     = memToReg ? 32'd0 : aluResult;
          end
        end else begin
          stateD = IDLE;
        end
      end
      REQ: begin
        if (mem_ack) begin
          stateD      = WB;
          wbValidD    = 1'b1;
          wbRegWriteD = latRegWrite;
          wbRegD      = latReg;
          wbDataD     = latMemToReg ? (latIsRead ? mem_rdata : 32'd0) : latAlu;
        end else if (ackLimitHitS) begin
          // Memory never answered: abandon the access and report it.
          stateD      = WB;
          wbValidD    = 1'b1;
          wbRegWriteD = 1'b0;
          wbRegD      = latReg;
          wbDataD     = latMemToReg ? 32'd0 : latAlu;
          errD        = 1'b1;
        end else begin
          memReqD   = 1'b1;
          memWeD    = mem_we;
          memAddrD  = mem_addr;
          memWdataD = mem_wdata;
          if (ACK_LIMIT != 32'd0) begin
            ackCntD = ackCnt + 32'd1;
          end else begin
            ackCntD = ackCnt;
          end
        end
      end
      default: begin
        stateD = IDLE;
      end
    endcase
  end

  // State, latched instruction fields and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ      <= IDLE;
      latRegWrite <= 1'b0;
      latMemToReg <= 1'b0;
      latIsRead   <= 1'b0;
      latReg      <= 5'd0;
      latAlu      <= 32'd0;
      ackCnt      <= 32'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_wdata   <= 32'd0;
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      wb_reg      <= 5'd0;
      wb_data     <= 32'd0;
      err         <= 1'b0;
    end else begin
      stateQ      <= stateD;
      latRegWrite <= latRegWriteD;
      latMemToReg <= latMemToRegD;
      latIsRead   <= latIsReadD;
      latReg      <= latRegD;
      latAlu      <= latAluD;
      ackCnt      <= ackCntD;
      mem_req     <= memReqD;
      mem_we      <= memWeD;
      mem_addr    <= memAddrD;
      mem_wdata   <= memWdataD;
      wb_valid    <= wbValidD;
      wb_regWrite <= wbRegWriteD;
      wb_reg      <= wbRegD;
      wb_data     <= wbDataD;
      err         <= errD;
    end
  end

endmodule

// File: tb/tb_mem_access_ctl.sv
// Self-checking bench for mem_access_ctl: directed scenarios followed by
// randomized transactions, each checked against a transaction-level model.
module tb_mem_access_ctl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        memRead, memWrite, memToReg, regWrite;
  logic [4:0]  writeReg;
  logic [31:0] aluResult, storeData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall, wb_valid, wb_regWrite;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_ctl #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .memRead(memRead), .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite),
    .writeReg(writeReg), .aluResult(aluResult), .storeData(storeData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .wb_valid(wb_valid), .wb_regWrite(wb_regWrite), .wb_reg(wb_reg),
    .wb_data(wb_data), .err(err)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle with nothing offered; optionally a stray ack that must be ignored.
  task automatic idle(input logic strayAck);
    in_valid = 1'b0;
    mem_ack  = strayAck;
    mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    chk1("idle_wb_valid", wb_valid, 1'b0);
    chk1("idle_mem_req", mem_req, 1'b0);
    chk1("idle_err", err, 1'b0);
    chk1("idle_in_ready", in_ready, 1'b1);
  endtask

  // Offer one instruction, play memory with the requested ack delay (number of
  // unacknowledged REQ cycles before the ack), and check the writeback beat.
  // Leaves the bench in the writeback cycle so a following call is back-to-back.
  task automatic runTxn(input logic rd, input logic wr, input logic m2r, input logic rw,
                        input logic [4:0] rg, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [31:0] rdv, input int ackDelay);
    logic isMem, misal, timedOut, errExp, expRw, dataKnown;
    logic [31:0] expData;
    int reqCycles;
    isMem = rd || wr;
    misal = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    misal = isMem && (alu[1:0] != 2'b00);
`endif
    timedOut = 1'b0;
    if (!isMem || misal) begin
      reqCycles = 0;
    end else if (ackDelay < TO) begin
      reqCycles = ackDelay + 1;
    end else begin
      reqCycles = TO;
      timedOut  = 1'b1;
    end
    errExp = timedOut || misal;
    expRw  = errExp ? 1'b0 : rw;
    dataKnown = 1'b1;
    expData   = alu;
    if (m2r) begin
      if (rd && !wr && !errExp) expData = rdv;
      else dataKnown = 1'b0;
    end

    chk1("accept_in_ready", in_ready, 1'b1);
    memRead = rd; memWrite = wr; memToReg = m2r; regWrite = rw;
    writeReg = rg; aluResult = alu; storeData = sd;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    aluResult = $urandom; storeData = $urandom; writeReg = 5'($urandom);
    for (int c = 1; c <= reqCycles; c++) begin
      chk1("req_mem_req", mem_req, 1'b1);
      chk1("req_mem_we", mem_we, wr);
      chk32("req_mem_addr", mem_addr, alu);
      if (wr) chk32("req_mem_wdata", mem_wdata, sd);
      chk1("req_stall", stall, 1'b1);
      chk1("req_wb_valid", wb_valid, 1'b0);
      mem_ack   = (!timedOut && (c == reqCycles));
      mem_rdata = mem_ack ? rdv : $urandom;
      tick();
      mem_ack = 1'b0;
    end
    chk1("wb_valid", wb_valid, 1'b1);
    chk1("wb_mem_req", mem_req, 1'b0);
    chk1("wb_regWrite", wb_regWrite, expRw);
    chk5("wb_reg", wb_reg, rg);
    chk1("wb_err", err, errExp);
    chk1("wb_stall", stall, 1'b0);
    if (dataKnown) chk32("wb_data", wb_data, expData);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    memRead = 1'b0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
    writeReg = 5'd0; aluResult = 32'd0; storeData = 32'd0;
    tick();
    tick();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_stall", stall, 1'b1);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'd0);
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk32("rst_wb_data", wb_data, 32'd0);
    chk1("rst_err", err, 1'b0);
    reset = 1'b0;
    #1;
    chk1("post_rst_in_ready", in_ready, 1'b1);

    // R-type: result straight to writeback next cycle.
    runTxn(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_002A, 32'd0, 32'd0, 0);
    idle(1'b0);
    // lw with memory answering in the third request cycle.
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 2);
    idle(1'b0);
    // sw acknowledged immediately.
    runTxn(1'b0, 1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0104, 32'h0000_1234, 32'd0, 0);
    idle(1'b0);
    // lw with no ack: timeout, then stray acks must do nothing.
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h0000_0200, 32'd0, 32'h1111_2222, 100);
    idle(1'b1);
    idle(1'b1);
    // Ack in the very cycle the limit is reached wins.
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h0000_0300, 32'd0, 32'hCAFE_F00D, TO - 1);
    // Both read and write set: behaves as a store.
    runTxn(1'b1, 1'b1, 1'b0, 1'b0, 5'd12, 32'h0000_0400, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 1);
    idle(1'b0);
    // Misaligned lw (passes through unless the alignment check is built in).
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h0000_0102, 32'd0, 32'h0BAD_F00D, 0);
    idle(1'b0);

    // Reset during REQ abandons the access with no writeback beat.
    memRead = 1'b1; memWrite = 1'b0; memToReg = 1'b1; regWrite = 1'b1;
    writeReg = 5'd14; aluResult = 32'h0000_0500; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("rreq_mem_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    chk1("rreq_in_ready", in_ready, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk1("rrel_mem_req", mem_req, 1'b0);
    chk1("rrel_wb_valid", wb_valid, 1'b0);
    chk1("rrel_err", err, 1'b0);
    chk1("rrel_in_ready", in_ready, 1'b1);
    idle(1'b1);
    runTxn(1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 32'h1357_9BDF, 32'd0, 32'd0, 0);

    // Back-to-back ALU ops then a load accepted in the writeback cycle.
    for (int i = 0; i < 3; i++) begin
      runTxn(1'b0, 1'b0, 1'b0, 1'b1, 5'(i + 1), $urandom, 32'd0, 32'd0, 0);
    end
    runTxn(1'b1, 1'b0, 1'b1, 1'b1, 5'd20, 32'h0000_0600, 32'd0, $urandom, 1);
    idle(1'b0);

    // Randomized mix of instruction kinds, memory latencies and gaps.
    for (int i = 0; i < 60; i++) begin
      logic rd, wr, m2r, rw;
      rd  = 1'($urandom_range(0, 1));
      wr  = 1'($urandom_range(0, 1));
      m2r = (rd || wr) ? 1'($urandom_range(0, 1)) : 1'b0;
      rw  = 1'($urandom_range(0, 1));
      runTxn(rd, wr, m2r, rw, 5'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 6)));
      if ($urandom_range(0, 1) == 1) idle(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
